// File: rtl/bram_test_sequencer_if.sv
// ---------------------------------------------------------------------------
// bram_test_sequencer_if
//   Bundles the campaign control inputs, the DUT-array drive/sense signals and
//   the board-level status outputs of bram_test_sequencer.
//
//   go          campaign start request
//   abort       abandon the running campaign
//   pass        AND-reduced pass from the BRAM DUT array
//   dut_start   one-cycle start pulse per run
//   dut_enable  duty-gated enable to the DUT array
//   busy        campaign in progress
//   done        campaign complete
//   fail_sticky at least one failing run this campaign
//   pass_count  passing runs this campaign (saturating)
//   fail_count  failing runs this campaign (saturating)
//
//   master : the side that requests campaigns and returns pass (board/TB)
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface bram_test_sequencer_if #(
    parameter int CNT_W = 16
) ();
    logic             go;
    logic             abort;
    logic             pass;
    logic             dut_start;
    logic             dut_enable;
    logic             busy;
    logic             done;
    logic             fail_sticky;
    logic [CNT_W-1:0] pass_count;
    logic [CNT_W-1:0] fail_count;

    modport master (
        output go, abort, pass,
        input  dut_start, dut_enable, busy, done, fail_sticky, pass_count, fail_count
    );

    modport slave (
        input  go, abort, pass,
        output dut_start, dut_enable, busy, done, fail_sticky, pass_count, fail_count
    );
endinterface

// File: rtl/bram_test_sequencer.sv
// ---------------------------------------------------------------------------
// bram_test_sequencer
//   Run controller for the non-cascaded BRAM DUT array. Each campaign performs
//   NUM_RUNS runs of START (1 cycle) / RUN (RUN_LEN) / SETTLE (SETTLE_LEN) /
//   CHECK (1 cycle). During RUN the array enable is gated by a
//   DUTY_ON-of-DUTY_PERIOD duty pattern for power characterisation. The
//   array's pass is sampled in CHECK and folded into saturating pass/fail
//   counters and a sticky failure flag.
//
//   clk_i   system clock
//   rst_i   synchronous, active-high reset
//   seq_if  slave modport of bram_test_sequencer_if (go/abort/pass in,
//           dut_start/dut_enable/busy/done/fail_sticky/counts out)
//
//   All outputs are registered; they are computed from the next state so that
//   they change on the same edge as the state they belong to.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_IDLE   | no campaign; waiting for go
//   S_START  | dut_start pulse, duty phase reset
//   S_RUN    | RUN_LEN cycles, duty-gated dut_enable
//   S_SETTLE | SETTLE_LEN cycles, enable low, array output settling
//   S_CHECK  | sample pass, update counts, pick next run or finish
//   S_DONE   | campaign complete; counts and flag held
// ---------------------------------------------------------------------------
module bram_test_sequencer #(
    parameter int NUM_RUNS    = 16,
    parameter int RUN_LEN     = 1024,
    parameter int SETTLE_LEN  = 8,
    parameter int DUTY_PERIOD = 4,
    parameter int DUTY_ON     = 4,
    parameter int CNT_W       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    bram_test_sequencer_if.slave  seq_if
);

    localparam int PH_W      = (DUTY_PERIOD > 1) ? $clog2(DUTY_PERIOD) : 1;
    localparam int MAX_LEN   = (RUN_LEN > SETTLE_LEN) ? RUN_LEN : SETTLE_LEN;
    // Cycle timer only ever holds length-1, so MAX_LEN-1 must fit.
    localparam int CYC_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int RUN_W     = (NUM_RUNS > 1) ? $clog2(NUM_RUNS) : 1;
    // DUTY_ON beyond the period behaves as 100%; clamping keeps the compare
    // narrow (phase+1 bits always holds DUTY_PERIOD).
    localparam int ON_CLAMP  = (DUTY_ON > DUTY_PERIOD) ? DUTY_PERIOD : DUTY_ON;
    localparam int RUN_M1    = RUN_LEN - 1;
    localparam int SETTLE_M1 = SETTLE_LEN - 1;
    localparam int PER_M1    = DUTY_PERIOD - 1;
    localparam int LAST_M1   = NUM_RUNS - 1;

    localparam logic [CYC_W-1:0] RUN_LOAD    = RUN_M1[CYC_W-1:0];
    localparam logic [CYC_W-1:0] SETTLE_LOAD = SETTLE_M1[CYC_W-1:0];
    localparam logic [PH_W-1:0]  PH_LAST     = PER_M1[PH_W-1:0];
    localparam logic [PH_W:0]    ON_LIM      = ON_CLAMP[PH_W:0];
    localparam logic [RUN_W-1:0] LAST_RUN    = LAST_M1[RUN_W-1:0];

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_RUN    = 3'd2,
        S_SETTLE = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            state_q,    state_d;
    logic [CYC_W-1:0]  cyc_q,      cyc_d;
    logic [PH_W-1:0]   phase_q,    phase_d;
    logic [RUN_W-1:0]  run_q,      run_d;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic              sticky_q,   sticky_d;
    logic              start_q,    start_d;
    logic              enable_q,   enable_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        phase_d    = phase_q;
        run_d      = run_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        sticky_d   = sticky_q;

        // abort beats go in IDLE/DONE and leaves counts for post-mortem.
        if (seq_if.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (seq_if.go) begin
                        state_d    = S_START;
                        run_d      = '0;
                        pass_cnt_d = '0;
                        fail_cnt_d = '0;
                        sticky_d   = 1'b0;
                    end
                end
                S_START: begin
                    state_d = S_RUN;
                    cyc_d   = RUN_LOAD;
                    phase_d = '0;
                end
                S_RUN: begin
                    if (cyc_q == '0) begin
                        state_d = S_SETTLE;
                        cyc_d   = SETTLE_LOAD;
                    end else begin
                        cyc_d   = cyc_q - CYC_W'(1);
                        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (cyc_q == '0) begin
                        state_d = S_CHECK;
                    end else begin
                        cyc_d = cyc_q - CYC_W'(1);
                    end
                end
                S_CHECK: begin
                    if (seq_if.pass) begin
                        if (pass_cnt_q != '1) begin
                            pass_cnt_d = pass_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        sticky_d = 1'b1;
                        if (fail_cnt_q != '1) begin
                            fail_cnt_d = fail_cnt_q + CNT_W'(1);
                        end
                    end
                    if (run_q == LAST_RUN) begin
                        state_d = S_DONE;
                    end else begin
                        run_d   = run_q + RUN_W'(1);
                        state_d = S_START;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        start_d  = (state_d == S_START);
        enable_d = (state_d == S_RUN) && ({1'b0, phase_d} < ON_LIM);
        busy_d   = (state_d inside {S_START, S_RUN, S_SETTLE, S_CHECK});
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cyc_q      <= '0;
            phase_q    <= '0;
            run_q      <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            sticky_q   <= 1'b0;
            start_q    <= 1'b0;
            enable_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            phase_q    <= phase_d;
            run_q      <= run_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            sticky_q   <= sticky_d;
            start_q    <= start_d;
            enable_q   <= enable_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign seq_if.dut_start   = start_q;
    assign seq_if.dut_enable  = enable_q;
    assign seq_if.busy        = busy_q;
    assign seq_if.done        = done_q;
    assign seq_if.fail_sticky = sticky_q;
    assign seq_if.pass_count  = pass_cnt_q;
    assign seq_if.fail_count  = fail_cnt_q;

endmodule
